// File: rtl/ring_monitor.sv
// ring_monitor: checks the one-hot rotation sequence of a ring counter.
// Two-stage input sampling (cur/prev), a four-state lock FSM, and
// registered position / lock / error / rotation reporting.
module ring_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 16,
  localparam int PW      = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Ring_in,
  input  logic             Dir,
  input  logic             Clear,
  output logic [PW-1:0]    Position,
  output logic             Onehot_ok,
  output logic             Locked,
  output logic             Err_sticky,
  output logic [7:0]       Err_count,
  output logic [CNT_W-1:0] Rotations
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_LOCKING = 2'd1,
    S_LOCKED  = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  s0, s1;
  logic [GW-1:0]     good_cnt, good_n;
  logic [WIDTH-1:0]  exp_cur;
  logic [PW-1:0]     idx;
  logic              onehot, step_ok, err_now, rot_inc;

  // Sample pipeline: s0 is the sample under check, s1 the one before it.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= Ring_in;
      s1 <= s0;
    end
  end

  // Sample classification: one-hot test, expected successor, bit index.
  always_comb begin
    onehot  = (s0 != '0) && ((s0 & (s0 - WIDTH'(1))) == '0);
    exp_cur = Dir ? {s1[0], s1[WIDTH-1:1]} : {s1[WIDTH-2:0], s1[WIDTH-1]};
    step_ok = onehot && (s0 == exp_cur);
    idx     = '0;
    for (int i = 0; i < WIDTH; i++)
      if (s0[i]) idx = PW'(i);
  end

  // Lock FSM next state; flags an error and a completed rotation.
  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    err_now = 1'b0;
    rot_inc = 1'b0;
    unique case (state)
      S_SEARCH: begin
        if (onehot) begin
          state_n = S_LOCKING;
          good_n  = GW'(1);
        end
      end
      S_LOCKING: begin
        if (step_ok) begin
          good_n = good_cnt + GW'(1);
          if (good_cnt + GW'(1) == GW'(LOCK_CNT)) state_n = S_LOCKED;
        end else if (onehot) begin
          good_n = GW'(1);
        end else begin
          state_n = S_SEARCH;
          good_n  = '0;
        end
      end
      S_LOCKED: begin
        if (step_ok) begin
          // A rotation completes when the token returns to its start bit.
          rot_inc = Dir ? (s0 == (WIDTH'(1) << (WIDTH - 1))) : (s0 == WIDTH'(1));
        end else begin
          state_n = S_ERROR;
          err_now = 1'b1;
        end
      end
      S_ERROR: begin
        state_n = S_SEARCH;
        good_n  = '0;
      end
      default: begin
        state_n = S_SEARCH;
        good_n  = '0;
      end
    endcase
  end

  // State and good-sample counter registers.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= S_SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_n;
      good_cnt <= good_n;
    end
  end

  // Registered outputs; a new error takes priority over Clear.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Position   <= '0;
      Onehot_ok  <= 1'b0;
      Locked     <= 1'b0;
      Err_sticky <= 1'b0;
      Err_count  <= '0;
      Rotations  <= '0;
    end else begin
      Onehot_ok <= onehot;
      if (onehot) Position <= idx;
      Locked <= (state_n == S_LOCKED);
      if (err_now) begin
        Err_sticky <= 1'b1;
        if (Clear)                  Err_count <= 8'd1;
        else if (Err_count != 8'hFF) Err_count <= Err_count + 8'd1;
      end else if (Clear) begin
        Err_sticky <= 1'b0;
        Err_count  <= '0;
      end
      if (rot_inc) Rotations <= Rotations + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ring_monitor.sv
// Directed bench for ring_monitor: a vector table for lock-up, error
// injection and Clear, then hand-written multi-cycle sequences.
module tb_ring_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ring;
  logic        dir, clr;
  logic [1:0]  pos;
  logic        ok, lk, st;
  logic [7:0]  ec;
  logic [15:0] rot;

  int n_vec = 0;
  int n_bad = 0;
  int last  = 3;

  ring_monitor #(.WIDTH(4), .LOCK_CNT(4), .CNT_W(16)) dut (
    .Clock(clk), .Reset(rst_n), .Ring_in(ring), .Dir(dir), .Clear(clr),
    .Position(pos), .Onehot_ok(ok), .Locked(lk), .Err_sticky(st),
    .Err_count(ec), .Rotations(rot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  ring;
    logic        d, c;
    logic [1:0]  pos;
    logic        ok, lk, st;
    logic [7:0]  ec;
    logic [15:0] rot;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one set of inputs, take one edge, settle past it.
  task automatic step(input logic r, input logic [3:0] rg, input logic d, input logic c);
    rst_n = r; ring = rg; dir = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  // Feed n clean ring samples continuing from the last token position.
  task automatic run_ring(input logic d, input int n, input logic c);
    for (int k = 0; k < n; k++) begin
      last = d ? (last + 3) % 4 : (last + 1) % 4;
      step(1'b1, 4'(1 << last), d, c);
    end
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'b0001, 1'b0, 1'b0);
    last = 3;
  endtask

  initial begin
    rst_n = 1'b0; ring = '0; dir = 1'b0; clr = 1'b0;
    //            r  ring     d  c  pos ok lk st ec rot
    tbl[0]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0};
    tbl[1]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0};
    tbl[2]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0};
    tbl[3]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0};
    tbl[4]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0};
    tbl[5]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0};
    tbl[6]  = '{1'b1, 4'b1000, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0};
    tbl[7]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 8'd0, 16'd0};
    tbl[8]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 16'd1};
    tbl[9]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'd0, 16'd1};
    tbl[10] = '{1'b1, 4'b0110, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 8'd0, 16'd1};
    tbl[11] = '{1'b1, 4'b0001, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1, 16'd1};
    tbl[12] = '{1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 8'd1, 16'd1};
    tbl[13] = '{1'b1, 4'b0100, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 8'd1, 16'd1};
    tbl[14] = '{1'b1, 4'b1000, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd1, 16'd1};
    tbl[15] = '{1'b1, 4'b0001, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 8'd1, 16'd1};
    tbl[16] = '{1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 8'd1, 16'd1};
    tbl[17] = '{1'b1, 4'b0100, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 8'd1, 16'd1};
    tbl[18] = '{1'b1, 4'b1000, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 8'd0, 16'd1};
    tbl[19] = '{1'b1, 4'b0001, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 8'd0, 16'd1};

    // Table: reset, lock-up, single bad sample, relock, Clear.
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].r, tbl[i].ring, tbl[i].d, tbl[i].c);
      chk($sformatf("tbl%0d.pos", i), 32'(pos), 32'(tbl[i].pos));
      chk($sformatf("tbl%0d.ok",  i), 32'(ok),  32'(tbl[i].ok));
      chk($sformatf("tbl%0d.lk",  i), 32'(lk),  32'(tbl[i].lk));
      chk($sformatf("tbl%0d.st",  i), 32'(st),  32'(tbl[i].st));
      chk($sformatf("tbl%0d.ec",  i), 32'(ec),  32'(tbl[i].ec));
      chk($sformatf("tbl%0d.rot", i), 32'(rot), 32'(tbl[i].rot));
    end

    // Ten full rotations after lock.
    do_reset(3);
    run_ring(1'b0, 45, 1'b0);
    chk("rot10.rot", 32'(rot), 32'd10);
    chk("rot10.lk",  32'(lk),  32'd1);
    chk("rot10.ec",  32'(ec),  32'd0);

    // Held sample while locked: one error, relock five edges later.
    run_ring(1'b0, 2, 1'b0);
    step(1'b1, 4'b0100, 1'b0, 1'b0);
    run_ring(1'b0, 1, 1'b0);
    chk("hold.lk",  32'(lk),  32'd0);
    chk("hold.st",  32'(st),  32'd1);
    chk("hold.ec",  32'(ec),  32'd1);
    chk("hold.rot", 32'(rot), 32'd11);
    run_ring(1'b0, 4, 1'b0);
    chk("hold.relock_early", 32'(lk), 32'd0);
    run_ring(1'b0, 1, 1'b0);
    chk("hold.relock", 32'(lk), 32'd1);
    chk("hold.ec2",    32'(ec), 32'd1);

    // Error counter saturation, Clear, Clear coincident with an error.
    do_reset(2);
    run_ring(1'b0, 5, 1'b0);
    chk("sat.lk0", 32'(lk), 32'd1);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 4'b0000, 1'b0, 1'b0);
      run_ring(1'b0, 6, 1'b0);
      if (i == 254) chk("sat.ec255", 32'(ec), 32'd255);
    end
    chk("sat.ec", 32'(ec), 32'd255);
    chk("sat.st", 32'(st), 32'd1);
    chk("sat.lk", 32'(lk), 32'd1);
    run_ring(1'b0, 1, 1'b1);
    chk("clear.ec", 32'(ec), 32'd0);
    chk("clear.st", 32'(st), 32'd0);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    run_ring(1'b0, 1, 1'b1);
    chk("clr_err.ec", 32'(ec), 32'd1);
    chk("clr_err.st", 32'(st), 32'd1);

    // Reset mid-lock, then Dir=1 relock, then a direction change.
    do_reset(2);
    run_ring(1'b0, 30, 1'b0);
    chk("pre_rst.rot", 32'(rot), 32'd7);
    chk("pre_rst.lk",  32'(lk),  32'd1);
    step(1'b0, 4'b0010, 1'b0, 1'b1);
    chk("rst.all", {pos, ok, lk, st, ec, rot}, 32'd0);
    last = 0;
    run_ring(1'b1, 14, 1'b0);
    chk("dir1.lk",  32'(lk),  32'd1);
    chk("dir1.rot", 32'(rot), 32'd3);
    chk("dir1.ec",  32'(ec),  32'd0);
    run_ring(1'b0, 5, 1'b0);
    chk("dirchg.lk_early", 32'(lk), 32'd0);
    run_ring(1'b0, 1, 1'b0);
    chk("dirchg.lk",  32'(lk),  32'd1);
    chk("dirchg.ec",  32'(ec),  32'd1);
    chk("dirchg.st",  32'(st),  32'd1);
    chk("dirchg.rot", 32'(rot), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
